// File: rtl/io_port_pkg.sv
// ---------------------------------------------------------------------------
// io_port_pkg
// Shared constants for the board input port. Defines how the CPU-visible
// in_port words are laid out and which raw pin value counts as "idle"
// (not active) for switches and pushbuttons.
// No ports; imported by io_input_port and debounce_bit.
// ---------------------------------------------------------------------------
package io_port_pkg;

  // Width of each CPU-visible input word in the data-memory IO map.
  localparam int IN_PORT_W = 10;

  // Field positions inside in_port1: key levels in the low nibble, sticky
  // key-press flags directly above them, top two bits always zero.
  localparam int IN1_KEY_LEVEL_LSB = 0;
  localparam int IN1_KEY_FLAG_LSB  = 4;

  // Raw pin value meaning "inactive": slide switches are active-high,
  // pushbuttons are active-low and read 1 while released.
  localparam logic SW_IDLE      = 1'b0;
  localparam logic KEY_RAW_IDLE = 1'b1;

  typedef logic [IN_PORT_W-1:0] in_port_t;

endpackage

// File: rtl/io_input_port_debounce.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Conditions one raw, asynchronous board input: a SYNC_STAGES-deep
// synchronizer followed by a debounce counter that only accepts a new level
// after DB_CYCLES consecutive synchronized samples disagree with the current
// level.
// Ports:
//   clk    in  CPU clock, all state on posedge
//   resetn in  asynchronous active-low reset
//   raw    in  raw pin, asynchronous to clk
//   idle   in  raw pin value that means "inactive"; the synchronizer resets
//              to it and the output level is normalized against it
//   level  out debounced level, active-high (1 = switch on / key pressed)
//   rise   out registered one-cycle pulse on the cycle level goes 0 -> 1
// ---------------------------------------------------------------------------
module debounce_bit
  import io_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 50000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  input  logic idle,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   s_active;

  // Next-state logic. The synchronized bit is XORed with the idle value so
  // that an active-low pushbutton reads as 1 when pressed; everything after
  // this point is active-high. The counter only runs while the synchronized
  // sample disagrees with the accepted level, and any agreeing sample
  // restarts it, so a glitch shorter than DB_CYCLES never gets through. The
  // counter flips the level exactly when it reaches DB_CYCLES-1 and is
  // cleared in the same step, which is why it can never wrap.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    s_active = sync_q[SYNC_STAGES-1] ^ idle;
    level_d  = level_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (s_active != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s_active;
        rise_d  = s_active;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers. On reset the synchronizer is filled with the idle pin
  // value, so releasing reset looks like "input inactive" and never produces
  // a spurious edge; any partially counted debounce is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= {SYNC_STAGES{idle}};
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/io_input_port.sv
// ---------------------------------------------------------------------------
// io_input_port
// Turns raw board switches and pushbuttons into clean CPU-readable words for
// the data-memory IO map. Every input bit gets its own synchronizer and
// debounce counter; pushbutton presses also set sticky flags that stay up
// until the CPU writes a one to the matching key_ack bit.
// Ports:
//   clk       in  CPU clock
//   resetn    in  asynchronous active-low reset
//   sw_raw    in  [N_SW]  raw slide switches, active-high
//   key_raw   in  [N_KEY] raw pushbuttons, active-low (0 = pressed)
//   key_ack   in  [N_KEY] write-one-to-clear pulse for key_flag
//   in_port0  out [10]    zero-extended debounced switch levels
//   in_port1  out [10]    {2'b00, key_flag, key_level}
//   key_event out [N_KEY] one-cycle pulse when a press is accepted
//   key_irq   out         OR of all key flags
// ---------------------------------------------------------------------------
module io_input_port
  import io_port_pkg::*;
#(
  parameter int N_SW        = 10,
  parameter int N_KEY       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_SW-1:0]      sw_raw,
  input  logic [N_KEY-1:0]     key_raw,
  input  logic [N_KEY-1:0]     key_ack,
  output logic [IN_PORT_W-1:0] in_port0,
  output logic [IN_PORT_W-1:0] in_port1,
  output logic [N_KEY-1:0]     key_event,
  output logic                 key_irq
);

  logic [N_SW-1:0]  sw_level;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] key_rise;
  logic [N_KEY-1:0] key_flag_q, key_flag_d;

  // One conditioner per switch. Switches only need their level; the edge
  // pulse is left open.
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_db (
      .clk   (clk),
      .resetn(resetn),
      .raw   (sw_raw[i]),
      .idle  (SW_IDLE),
      .level (sw_level[i]),
      .rise  ()
    );
  end

  // One conditioner per pushbutton. Passing the released pin value as idle
  // is what inverts the active-low buttons into active-high levels.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_db (
      .clk   (clk),
      .resetn(resetn),
      .raw   (key_raw[i]),
      .idle  (KEY_RAW_IDLE),
      .level (key_level[i]),
      .rise  (key_rise[i])
    );
  end

  assign key_event = key_rise;

  // Sticky press flags. The flag is set at the edge that ends the
  // key_event cycle. The set term is ORed in after the acknowledge clears,
  // so an ack landing on the same cycle as a new press leaves the flag up
  // and the press is never lost.
  always_comb begin
    key_flag_d = (key_flag_q & ~key_ack) | key_event;
  end

  // Flag register, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_flag_q <= '0;
    end else begin
      key_flag_q <= key_flag_d;
    end
  end

  // Port packing and interrupt. These are straight views of the level and
  // flag registers so the CPU sees them with no added latency. Unused
  // upper bits stay zero when fewer switches or keys are fitted.
  always_comb begin
    in_port0                               = IN_PORT_W'(sw_level);
    in_port1                               = '0;
    in_port1[IN1_KEY_LEVEL_LSB +: N_KEY]   = key_level;
    in_port1[IN1_KEY_FLAG_LSB  +: N_KEY]   = key_flag_q;
    key_irq                                = |key_flag_q;
  end

endmodule

// File: tb/tb_io_input_port.sv
// ---------------------------------------------------------------------------
// tb_io_input_port
// Bench for io_input_port with a short debounce (DB_CYCLES=4, SYNC_STAGES=2).
// A reference model follows every clock edge: an input bit's level flips when
// the last DB synchronized samples (raw samples delayed by SYNC edges) all
// disagree with the current level. Table vectors, hand-written sequences for
// reset, bounce and ack collisions, and a random run all compare against it.
// ---------------------------------------------------------------------------
module tb_io_input_port;

  localparam int N_SW  = 10;
  localparam int N_KEY = 4;
  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int NB    = N_SW + N_KEY;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] sw_raw = 10'h000;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_ack = 4'h0;
  logic [9:0] in_port0;
  logic [9:0] in_port1;
  logic [3:0] key_event;
  logic       key_irq;

  int pass_count  = 0;
  int check_count = 0;

  logic [NB-1:0] m_hist[$];
  logic [NB-1:0] m_level;
  logic [3:0]    m_flag;
  logic [3:0]    m_event;

  typedef struct {
    logic [9:0] sw;
    logic [3:0] key;
    logic [3:0] ack;
    int         cycles;
    logic [9:0] exp_in0;
    logic [9:0] exp_in1;
    logic [3:0] exp_evt;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[13];

  io_input_port #(
    .N_SW       (N_SW),
    .N_KEY      (N_KEY),
    .SYNC_STAGES(SYNC),
    .DB_CYCLES  (DB),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sw_raw   (sw_raw),
    .key_raw  (key_raw),
    .key_ack  (key_ack),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .key_event(key_event),
    .key_irq  (key_irq)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive all data inputs at once.
  task automatic applyStimulus(input logic [9:0] sw, input logic [3:0] key, input logic [3:0] ack);
    sw_raw  = sw;
    key_raw = key;
    key_ack = ack;
  endtask

  // Reference model reset: history holds idle samples, nothing pressed.
  function automatic void modelReset();
    m_hist.delete();
    repeat (6) m_hist.push_back('0);
    m_level = '0;
    m_flag  = '0;
    m_event = '0;
  endfunction

  // Reference model update for one clock edge, using the inputs present at
  // that edge. Inputs are converted to active-high before being recorded.
  function automatic void modelStep();
    logic [NB-1:0] act;
    logic [NB-1:0] nxt;
    logic [3:0]    nflag;
    int            n;
    bit            all_diff;
    act = {~key_raw, sw_raw};
    m_hist.push_back(act);
    n     = m_hist.size();
    nflag = (m_flag & ~key_ack) | m_event;
    nxt   = m_level;
    for (int b = 0; b < NB; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (m_hist[n - 1 - SYNC - j][b] == m_level[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~m_level[b];
    end
    m_event = nxt[NB-1:N_SW] & ~m_level[NB-1:N_SW];
    m_level = nxt;
    m_flag  = nflag;
    if (n > 12) void'(m_hist.pop_front());
  endfunction

  // Advance one clock edge, update the model and compare all outputs 1 ns
  // after the edge.
  task automatic stepCycle();
    @(posedge clk);
    if (resetn) modelStep();
    #1;
    checkOutput("model_cycle",
                {7'b0, in_port0, in_port1, key_event, key_irq},
                {7'b0, m_level[9:0], 2'b00, m_flag, m_level[NB-1:N_SW], m_event, |m_flag});
  endtask

  // Assert reset with the given raw inputs, check the async clear, hold a
  // couple of edges and release on a falling edge.
  task automatic doReset(input logic [9:0] sw, input logic [3:0] key);
    applyStimulus(sw, key, 4'h0);
    resetn = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_outputs", {7'b0, in_port0, in_port1, key_event, key_irq}, 32'h0);
    repeat (2) stepCycle();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [9:0] bounce[9];
    bit         found;

    vecs[0]  = '{10'h155, 4'hF, 4'h0,  6, 10'h155, 10'h000, 4'h0, 1'b0};
    vecs[1]  = '{10'h2AA, 4'hF, 4'h0,  5, 10'h155, 10'h000, 4'h0, 1'b0};
    vecs[2]  = '{10'h2AA, 4'hF, 4'h0,  1, 10'h2AA, 10'h000, 4'h0, 1'b0};
    vecs[3]  = '{10'h2AA, 4'hB, 4'h0,  6, 10'h2AA, 10'h004, 4'h4, 1'b0};
    vecs[4]  = '{10'h2AA, 4'hB, 4'h0,  1, 10'h2AA, 10'h044, 4'h0, 1'b1};
    vecs[5]  = '{10'h2AA, 4'hB, 4'h0, 13, 10'h2AA, 10'h044, 4'h0, 1'b1};
    vecs[6]  = '{10'h2AA, 4'hF, 4'h0,  6, 10'h2AA, 10'h040, 4'h0, 1'b1};
    vecs[7]  = '{10'h2AA, 4'hF, 4'h4,  1, 10'h2AA, 10'h000, 4'h0, 1'b0};
    vecs[8]  = '{10'h2AA, 4'hF, 4'h4,  1, 10'h2AA, 10'h000, 4'h0, 1'b0};
    vecs[9]  = '{10'h2AA, 4'hE, 4'h0,  6, 10'h2AA, 10'h001, 4'h1, 1'b0};
    vecs[10] = '{10'h2AA, 4'hE, 4'h0,  1, 10'h2AA, 10'h011, 4'h0, 1'b1};
    vecs[11] = '{10'h2AA, 4'hF, 4'h1,  1, 10'h2AA, 10'h001, 4'h0, 1'b0};
    vecs[12] = '{10'h2AA, 4'hF, 4'h0,  6, 10'h2AA, 10'h000, 4'h0, 1'b0};

    // Reset with everything active, then count edges to the first accept.
    doReset(10'h3FF, 4'h0);
    for (int e = 1; e <= 7; e++) begin
      stepCycle();
      if (e == 5) checkOutput("t1_in0_edge5", {22'b0, in_port0}, 32'h000);
      if (e == 6) begin
        checkOutput("t1_in0_edge6", {22'b0, in_port0}, 32'h3FF);
        checkOutput("t1_in1_edge6", {22'b0, in_port1}, 32'h00F);
        checkOutput("t1_evt_edge6", {28'b0, key_event}, 32'hF);
      end
      if (e == 7) begin
        checkOutput("t1_in1_edge7", {22'b0, in_port1}, 32'h0FF);
        checkOutput("t1_irq_edge7", {31'b0, key_irq}, 32'h1);
        checkOutput("t1_evt_edge7", {28'b0, key_event}, 32'h0);
      end
    end

    // Bounce on switch 0, then a clean hold.
    doReset(10'h000, 4'hF);
    bounce = '{10'h1, 10'h0, 10'h1, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(bounce[i], 4'hF, 4'h0);
      stepCycle();
      checkOutput($sformatf("t2_bounce_%0d", i), {31'b0, in_port0[0]}, 32'h0);
    end
    applyStimulus(10'h001, 4'hF, 4'h0);
    for (int e = 1; e <= 6; e++) begin
      stepCycle();
      if (e == 5) checkOutput("t2_hold_edge5", {31'b0, in_port0[0]}, 32'h0);
      if (e == 6) checkOutput("t2_hold_edge6", {31'b0, in_port0[0]}, 32'h1);
    end

    // Reset arriving while key 0 is part-way through its debounce.
    doReset(10'h000, 4'hF);
    applyStimulus(10'h000, 4'hE, 4'h0);
    repeat (3) stepCycle();
    resetn = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_in1_in_reset", {22'b0, in_port1}, 32'h000);
    @(negedge clk);
    resetn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      stepCycle();
      if (e == 5) checkOutput("t6_level_edge5", {31'b0, in_port1[0]}, 32'h0);
      if (e == 6) checkOutput("t6_level_edge6", {31'b0, in_port1[0]}, 32'h1);
    end

    // Table of press, release and acknowledge vectors.
    doReset(10'h000, 4'hF);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].sw, vecs[i].key, vecs[i].ack);
      repeat (vecs[i].cycles) stepCycle();
      checkOutput($sformatf("vec%0d_in0", i), {22'b0, in_port0}, {22'b0, vecs[i].exp_in0});
      checkOutput($sformatf("vec%0d_in1", i), {22'b0, in_port1}, {22'b0, vecs[i].exp_in1});
      checkOutput($sformatf("vec%0d_evt", i), {28'b0, key_event}, {28'b0, vecs[i].exp_evt});
      checkOutput($sformatf("vec%0d_irq", i), {31'b0, key_irq}, {31'b0, vecs[i].exp_irq});
    end

    // Acknowledge on the exact cycle a new press event fires.
    applyStimulus(10'h2AA, 4'hD, 4'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      stepCycle();
      if (key_event[1]) found = 1'b1;
    end
    checkOutput("t5_event_seen", {31'b0, found}, 32'h1);
    if (found) begin
      applyStimulus(10'h2AA, 4'hD, 4'h2);
      stepCycle();
      applyStimulus(10'h2AA, 4'hD, 4'h0);
      checkOutput("t5_flag_kept", {31'b0, in_port1[5]}, 32'h1);
      checkOutput("t5_irq_kept", {31'b0, key_irq}, 32'h1);
    end

    // Random stimulus with bursty input changes so levels really move.
    doReset(10'h000, 4'hF);
    for (int i = 0; i < 800; i++) begin
      logic [9:0] sw_n;
      logic [3:0] key_n;
      logic [3:0] ack_n;
      sw_n  = sw_raw;
      key_n = key_raw;
      if ($urandom_range(0, 7) == 0) sw_n = 10'($urandom());
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, 3)] = ~key_n[$urandom_range(0, 3)];
      ack_n = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
      applyStimulus(sw_n, key_n, ack_n);
      stepCycle();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
